seg7_scan_rx: RTL
=================

Name: seg7_scan_rx

Overview:
- Receiver/decoder for the multiplexed seven-segment display interface: the inverse of the team's BCD-to-7-segment encoder path.
- Watches a scanned display bus (one-hot digit select plus active-low segment pattern) and debounces each digit dwell.
- Decodes each segment pattern back to BCD and assembles a full NDIG-digit frame, delivered on a valid/ready handshake.
- Used as a display monitor in NPC simulation and as a loopback checker behind the display driver.

Parameters:
- NDIG, 8, number of scanned digits (2..16).
- STABLE_CYC, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_i  input  7  segment pattern, active-low (0 = segment lit). Bit order {a,b,c,d,e,f,g}: bit6 = a, bit0 = g.
- sel_i  input  NDIG  digit select, one-hot, active-high. Bit i selects digit i.
- out_valid  output  1  a complete frame is available.
- out_ready  input  1  consumer accepts the frame.
- out_data  output  4*NDIG  decoded frame; digit i is at [4i+3:4i].
- out_err  output  NDIG  per-digit illegal-pattern flag for the presented frame.
- overrun  output  1  sticky flag: a completed frame was dropped.

Behaviour:
- Decode table (seg_i to code):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4.
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111→4'hF (blank, legal, err=0).
  - Any other pattern→4'hE with err=1.
- Sampling:
  - sample register {s_seg, s_sel} loads {seg_i, sel_i} every cycle.
  - A sample is legal only if sel_i is exactly one-hot.
- Dwell counter cnt (width ceil(log2(STABLE_CYC+1))), updated each edge:
  - Legal sample equal to the previous sample: cnt increments, saturating at STABLE_CYC.
  - Legal sample that differs from the previous one: cnt = 1.
  - Illegal sample (sel zero or multi-hot): cnt = 0.
- Dwell FSM:
  - States WAIT_STABLE and CAPTURED.
  - WAIT_STABLE→CAPTURED on the edge where cnt reaches STABLE_CYC, i.e. the STABLE_CYC-th consecutive identical legal sample.
  - On that same edge: write the digit code and err into slot idx (idx = index of the set sel bit), and set seen[idx].
  - CAPTURED→WAIT_STABLE on any change of the sample or on an illegal sample.
  - Each digit is captured at most once per dwell.
  - Re-capturing an already-seen digit before frame completion overwrites that slot; it does not add to seen.
- Frame completion:
  - Occurs on the edge where seen becomes all ones, including the edge that captures the last missing digit. seen clears to 0 on the same edge.
  - If out_valid=0, or out_valid=1 with out_ready=1 on that edge: load out_data/out_err from the slots (including the digit captured that edge) and set out_valid=1.
  - If out_valid=1 and out_ready=0: drop the new frame, keep the presented data unchanged, set overrun=1.
- Handshake:
  - Transfer occurs on an edge with out_valid & out_ready.
  - out_valid drops the next cycle unless a new frame completes on that same edge.
  - out_data and out_err are stable while out_valid=1 and out_ready=0.
- Latency: a digit held from edge 1 is captured at edge STABLE_CYC. With all other digits already seen, out_valid is visible right after that edge.
- Reset:
  - Clears out_valid, out_data, out_err, overrun, seen, slots, sample registers and cnt, and sets the FSM to WAIT_STABLE.
  - Reset mid-dwell or mid-frame discards all partial data.
  - overrun clears only on reset.

Optional Feature:
- Macro SEG7RX_DP_EN.
- When defined:
  - Adds input dp_i (1 bit, active-low decimal point) and output out_dp (NDIG bits).
  - dp_i is part of the sample and the stability comparison, and is captured per digit alongside the code.
  - out_dp[i] = 1 when the decimal point was lit.
- When undefined: no dp ports; behaviour exactly as above.

Test Plan:
- Basic capture: NDIG=8, STABLE_CYC=4. Scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, holding each for 6 cycles, out_ready=1 → after digit 7's 4th edge, out_valid=1 for one cycle and out_data=32'h87654321, out_err=0.
- Glitch rejection: hold sel_i=8'h01 with "3" for 3 cycles, then change → nothing captured. Hold "3" for 4 cycles → slot0=3.
- Illegal inputs: seg_i=7'b1010101 on digit 2 → frame out_err=8'h04 and nibble 2 = 4'hE. sel_i=8'h03 for 10 cycles → no capture.
- Backpressure: out_ready=0 and complete two frames → first frame held unchanged, overrun=1. Then out_ready=1 → transfer, out_valid falls.
- Blank: all digits 1111111 → out_data=32'hFFFFFFFF, out_err=0.
- Reset mid-frame: capture digits 0..3, pulse rst, then scan a full frame → output contains only post-reset data and overrun=0.

Source files
------------

// File: rtl/seg7_scan_rx.sv
// Scanned seven-segment display receiver: debounces each digit dwell, decodes it to BCD
// and delivers whole NDIG-digit frames on a valid/ready handshake. Optional SEG7RX_DP_EN adds decimal points.
module seg7_scan_rx #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     sel_i,
`ifdef SEG7RX_DP_EN
    input  logic                dp_i,
    output logic [NDIG-1:0]     out_dp,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_data,
    output logic [NDIG-1:0]     out_err,
    output logic                overrun
);

    localparam int CW = $clog2(STABLE_CYC + 1);
`ifdef SEG7RX_DP_EN
    localparam int SW = 8 + NDIG;
`else
    localparam int SW = 7 + NDIG;
`endif
    localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CYC);

    typedef enum logic [0:0] {
        WAIT_STABLE = 1'b0,
        CAPTURED    = 1'b1
    } state_t;

    // Returns {err, code}; blank is a legal code, anything unlisted is flagged.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'h00;
            7'b1001111: res = 5'h01;
            7'b0010010: res = 5'h02;
            7'b0000110: res = 5'h03;
            7'b1001100: res = 5'h04;
            7'b0100100: res = 5'h05;
            7'b0100000: res = 5'h06;
            7'b0001111: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0000100: res = 5'h09;
            7'b1111111: res = 5'h0F;
            default:    res = 5'h1E;
        endcase
        return res;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [SW-1:0]       r_sample;
    logic [SW-1:0]       w_sample;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                w_legal;
    logic                w_same;
    logic                w_capture;
    logic [4:0]          w_dec;
    logic [NDIG-1:0]     r_seen;
    logic [NDIG-1:0]     w_seen_acc;
    logic                w_frame_done;
    logic [4*NDIG-1:0]   r_slot_data;
    logic [4*NDIG-1:0]   w_slot_data_next;
    logic [NDIG-1:0]     r_slot_err;
    logic [NDIG-1:0]     w_slot_err_next;
    logic                r_out_valid;
    logic [4*NDIG-1:0]   r_out_data;
    logic [NDIG-1:0]     r_out_err;
    logic                r_overrun;
`ifdef SEG7RX_DP_EN
    logic [NDIG-1:0]     r_slot_dp;
    logic [NDIG-1:0]     w_slot_dp_next;
    logic [NDIG-1:0]     r_out_dp;
    assign w_sample = {dp_i, seg_i, sel_i};
    assign out_dp   = r_out_dp;
`else
    assign w_sample = {seg_i, sel_i};
`endif

    assign w_legal = (sel_i != '0) && ((sel_i & (sel_i - 1'b1)) == '0);
    assign w_same  = (w_sample == r_sample);
    assign w_dec   = seg_decode(seg_i);

    // Dwell counter next value: saturating run length of identical legal samples.
    always_comb begin
        w_cnt_next = '0;
        if (!w_legal) begin
            w_cnt_next = '0;
        end else if (!w_same) begin
            w_cnt_next = CW'(1);
        end else if (r_cnt == STABLE_V) begin
            w_cnt_next = STABLE_V;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    // Sample, counter and dwell state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_state  <= WAIT_STABLE;
        end else begin
            r_sample <= w_sample;
            r_cnt    <= w_cnt_next;
            r_state  <= w_state_next;
        end
    end

    // Dwell FSM next state: leave CAPTURED only once the dwell ends.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_STABLE: begin
                if (w_capture) w_state_next = CAPTURED;
                else           w_state_next = WAIT_STABLE;
            end
            CAPTURED: begin
                if (!w_legal || !w_same) w_state_next = WAIT_STABLE;
                else                     w_state_next = CAPTURED;
            end
            default: w_state_next = WAIT_STABLE;
        endcase
    end

    // Dwell FSM output: one capture strobe per stable dwell.
    always_comb begin
        w_capture = 1'b0;
        if (r_state == WAIT_STABLE) begin
            w_capture = w_legal && (w_cnt_next == STABLE_V);
        end else begin
            w_capture = 1'b0;
        end
    end

    // Slot update including the digit captured this edge, so frame output sees it.
    always_comb begin
        w_slot_data_next = r_slot_data;
        w_slot_err_next  = r_slot_err;
`ifdef SEG7RX_DP_EN
        w_slot_dp_next   = r_slot_dp;
`endif
        for (int i = 0; i < NDIG; i++) begin
            if (w_capture && sel_i[i]) begin
                w_slot_data_next[4*i +: 4] = w_dec[3:0];
                w_slot_err_next[i]         = w_dec[4];
`ifdef SEG7RX_DP_EN
                w_slot_dp_next[i]          = ~dp_i;
`endif
            end else begin
                w_slot_data_next[4*i +: 4] = r_slot_data[4*i +: 4];
                w_slot_err_next[i]         = r_slot_err[i];
            end
        end
    end

    assign w_seen_acc   = r_seen | (w_capture ? sel_i : {NDIG{1'b0}});
    assign w_frame_done = &w_seen_acc;

    // Slot and seen-mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen      <= '0;
            r_slot_data <= '0;
            r_slot_err  <= '0;
`ifdef SEG7RX_DP_EN
            r_slot_dp   <= '0;
`endif
        end else begin
            r_seen      <= w_frame_done ? {NDIG{1'b0}} : w_seen_acc;
            r_slot_data <= w_slot_data_next;
            r_slot_err  <= w_slot_err_next;
`ifdef SEG7RX_DP_EN
            r_slot_dp   <= w_slot_dp_next;
`endif
        end
    end

    // Output frame register with handshake; a frame arriving under backpressure is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
            r_overrun   <= 1'b0;
`ifdef SEG7RX_DP_EN
            r_out_dp    <= '0;
`endif
        end else if (w_frame_done && (!r_out_valid || out_ready)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_slot_data_next;
            r_out_err   <= w_slot_err_next;
`ifdef SEG7RX_DP_EN
            r_out_dp    <= w_slot_dp_next;
`endif
        end else if (w_frame_done) begin
            r_overrun   <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign overrun   = r_overrun;

endmodule
